add_sub_serial: RTL
===================

Name: add_sub_serial

Overview:
- Parametrised, multi-cycle, digit-serial adder/subtractor for the EB/ALU datapath.
- Generalises the 1-bit full adder cell to WIDTH-bit operands, processing DIGIT bits per clock (LSB first) through one DIGIT-wide carry chain.
- Trades latency for area; reports carry, signed overflow and zero flags.
- Start/busy/done handshake lets the control unit stall while the result forms.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits processed per cycle; 1 = bit-serial, WIDTH = single-cycle pass.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when the block can accept.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse when a new result is valid.
- s  output  WIDTH  result; holds last completed value.
- co  output  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  output  1  two's-complement overflow.
- zero  output  1  1 when s == 0.

Behaviour:
- Reset (async, any time): state=IDLE; busy=0, done=0, s=0, co=0, ovf=0, zero=0. Internal shift registers, carry and counter cleared. Reset mid-operation aborts with no done.
- N = WIDTH/DIGIT. Counter width = clog2(N), minimum 1 bit.
- States:
  - IDLE: busy=0, done=0. On start=1 at an edge: latch A=a, B=(sub ? ~b : b), carry=sub, count=0; capture msbA=a[WIDTH-1], msbB=B[WIDTH-1]; go to RUN.
  - RUN: busy=1. Each edge: {carry, digit} = A[DIGIT-1:0] + B[DIGIT-1:0] + carry. Shift A and B right by DIGIT. Shift digit into the top of the result shift register. count++. On the edge where count==N-1, commit outputs and go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start=1 in DONE is accepted as in IDLE (back-to-back), going directly to RUN; done still pulses that cycle.
- Commit, on the final RUN edge:
  - s = full result.
  - co = final carry.
  - ovf = (msbA == msbB) && (s[WIDTH-1] != msbA).
  - zero = (s == 0).
- Latency: start sampled at edge k → done high in the cycle after edge k+N. Throughput is one op per N+1 cycles.
- s, co, ovf and zero change only at commit or reset. They are stable during RUN and keep the previous result.
- start while busy=1 is ignored: no queueing, and operands are not re-sampled.
- a, b and sub may change freely after the start edge.
- DIGIT==WIDTH: N=1, so one RUN cycle. The datapath is unchanged.

Test Plan:
- WIDTH=8, DIGIT=2, add, a=0x7F, b=0x01, start at edge 0:
  - busy high for edges 1–4; done pulses the cycle after edge 4.
  - s=0x80, co=0, ovf=1, zero=0.
- Add, a=0xFF, b=0x01: s=0x00, co=1, ovf=0, zero=1.
- Subtract, sub=1:
  - a=0x05, b=0x05: s=0x00, co=1, ovf=0, zero=1.
  - a=0x80, b=0x01: s=0x7F, co=1, ovf=1.
  - a=0x00, b=0x01: s=0xFF, co=0, ovf=0.
- Handshake:
  - Pulse start again during RUN with different operands: ignored; original result committed; s unchanged in RUN.
  - start asserted in the DONE cycle: second op accepted; its done arrives N+1 cycles after the first.
- Assert rst at RUN count 2: all outputs 0 immediately (async); no done. A subsequent op completes correctly.
- Random sweep, ≥1000 ops each for (WIDTH,DIGIT) = (8,1), (8,2), (8,8), (16,4):
  - s, co, ovf, zero match a reference model.
  - done latency is exactly N+1 cycles from the start edge.

Source files
------------

// File: rtl/add_sub_serial.sv
// add_sub_serial: digit-serial WIDTH-bit add/sub (start/sub/a/b in; busy/done/s/co/ovf/zero out), DIGIT bits per clock LSB first
module add_sub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d, b_in, r_next;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DIGIT:0] sum;
  logic carry_q, carry_d, msba_q, msba_d, msbb_q, msbb_d;
  logic co_q, co_d, ovf_q, ovf_d, zero_q, zero_d;
  logic run, accept, last;
  always_comb begin
    run     = state_q == RUN;
    accept  = start && !run;
    last    = run && cnt_q == CW'(N - 1);
    b_in    = sub ? ~b : b;
    sum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    cat     = {sum[DIGIT-1:0], r_q};
    r_next  = cat[WIDTH+DIGIT-1:DIGIT];
    state_d = accept ? RUN : last ? DONE : run ? RUN : IDLE;
    a_d     = accept ? a : run ? a_q >> DIGIT : a_q;
    b_d     = accept ? b_in : run ? b_q >> DIGIT : b_q;
    carry_d = accept ? sub : run ? sum[DIGIT] : carry_q;
    cnt_d   = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    r_d     = run ? r_next : r_q;
    msba_d  = accept ? a[WIDTH-1] : msba_q;
    msbb_d  = accept ? b_in[WIDTH-1] : msbb_q;
    s_d     = last ? r_next : s_q;
    co_d    = last ? sum[DIGIT] : co_q;
    ovf_d   = last ? (msba_q == msbb_q) && (r_next[WIDTH-1] != msba_q) : ovf_q;
    zero_d  = last ? r_next == '0 : zero_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      msba_q  <= 1'b0;
      msbb_q  <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      msba_q  <= msba_d;
      msbb_q  <= msbb_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
endmodule
